// File: rtl/biquad_cascade_sequencer_if.sv
// Sample, coefficient and status signals between the host and the biquad cascade sequencer.
// The host drives through the master modport. The sequencer drives through the slave modport.
interface biquad_cascade_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ADDR_W = 5
);
    logic signed [DATA_W-1:0] sample_in;
    logic                     sample_in_valid;
    logic                     sample_in_ready;
    logic signed [DATA_W-1:0] sample_out;
    logic                     sample_out_valid;
    logic                     coef_wr_en;
    logic        [ADDR_W-1:0] coef_wr_addr;
    logic signed [COEF_W-1:0] coef_wr_data;
    logic                     coef_commit;
    logic                     commit_pending;
    logic        [7:0]        overrun_count;

    modport master (
        output sample_in, sample_in_valid, coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
        input  sample_in_ready, sample_out, sample_out_valid, commit_pending, overrun_count
    );

    modport slave (
        input  sample_in, sample_in_valid, coef_wr_en, coef_wr_addr, coef_wr_data, coef_commit,
        output sample_in_ready, sample_out, sample_out_valid, commit_pending, overrun_count
    );
endinterface

// File: rtl/biquad_cascade_sequencer.sv
// Time-multiplexed biquad cascade controller that shares one MAC across NUM_STAGES stages.
// It holds a double-buffered coefficient bank. A commit only takes effect at a sample boundary.
//
//   state | meaning
//   IDLE  | waiting for a sample strobe, sample_in_ready high
//   MAC   | accumulating one tap per clock (b0,b1,b2,a1,a2) for the current stage
//   WB    | shift/saturate result, update stage history, advance or emit output
module biquad_cascade_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int COEF_FRAC  = 14,
    parameter int ACC_W      = 40,
    parameter int ADDR_W     = $clog2(5*NUM_STAGES)
) (
    input logic clk,
    input logic reset,
    biquad_cascade_sequencer_if.slave bus
);
    localparam int NUM_COEF = 5*NUM_STAGES;
    localparam int STG_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int PROD_W   = COEF_W + DATA_W;
    localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(2**COEF_FRAC);
    localparam logic signed [DATA_W-1:0] Y_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, WB} state_t;

    state_t                   state;
    logic [STG_W-1:0]         stage;
    logic [2:0]               tap;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] x_cur;
    logic signed [DATA_W-1:0] x1 [NUM_STAGES];
    logic signed [DATA_W-1:0] x2 [NUM_STAGES];
    logic signed [DATA_W-1:0] y1 [NUM_STAGES];
    logic signed [DATA_W-1:0] y2 [NUM_STAGES];
    logic signed [COEF_W-1:0] coef_act [NUM_COEF];
    logic signed [COEF_W-1:0] coef_shd [NUM_COEF];
    logic signed [DATA_W-1:0] sample_out_r;
    logic                     sample_out_valid_r;
    logic                     commit_pending_r;
    logic [7:0]               overrun_count_r;

    logic [ADDR_W-1:0]        coef_idx;
    logic signed [COEF_W-1:0] coef_sel;
    logic signed [DATA_W-1:0] data_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  acc_sh;
    logic [ACC_W-DATA_W:0]    acc_upper;
    logic signed [DATA_W-1:0] y_sat;
    logic                     last_stage;
    logic                     commit_now;

    always_comb begin
        coef_idx = ADDR_W'(stage) * ADDR_W'(5) + ADDR_W'(tap);
        coef_sel = coef_act[coef_idx];
        case (tap)
            3'd0:    data_sel = x_cur;
            3'd1:    data_sel = x1[stage];
            3'd2:    data_sel = x2[stage];
            3'd3:    data_sel = y1[stage];
            default: data_sel = y2[stage];
        endcase
        prod     = coef_sel * data_sel;
        prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        // Floor shift, then clamp unless the upper bits are a pure sign extension.
        acc_sh    = acc >>> COEF_FRAC;
        acc_upper = acc_sh[ACC_W-1:DATA_W-1];
        if ((&acc_upper) || !(|acc_upper)) y_sat = acc_sh[DATA_W-1:0];
        else                               y_sat = acc_sh[ACC_W-1] ? Y_MIN : Y_MAX;
        last_stage = (stage == STG_W'(NUM_STAGES-1));
        commit_now = (commit_pending_r || bus.coef_commit) &&
                     ((state == IDLE) || ((state == WB) && last_stage));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            stage              <= '0;
            tap                <= '0;
            acc                <= '0;
            x_cur              <= '0;
            sample_out_r       <= '0;
            sample_out_valid_r <= 1'b0;
            commit_pending_r   <= 1'b0;
            overrun_count_r    <= '0;
            for (int i = 0; i < NUM_STAGES; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
            for (int i = 0; i < NUM_COEF; i++) begin
                coef_act[i] <= (i % 5 == 0) ? COEF_ONE : '0;
                coef_shd[i] <= (i % 5 == 0) ? COEF_ONE : '0;
            end
        end else begin
            sample_out_valid_r <= 1'b0;
            // Copy takes the shadow contents from before any write on this same edge.
            if (commit_now) coef_act <= coef_shd;
            if (bus.coef_wr_en && (int'(bus.coef_wr_addr) < NUM_COEF))
                coef_shd[bus.coef_wr_addr] <= bus.coef_wr_data;
            commit_pending_r <= commit_now ? 1'b0 : (commit_pending_r || bus.coef_commit);
            if (bus.sample_in_valid && (state != IDLE) && (overrun_count_r != 8'hFF))
                overrun_count_r <= overrun_count_r + 8'd1;

            case (state)
                IDLE: begin
                    if (bus.sample_in_valid) begin
                        x_cur <= bus.sample_in;
                        stage <= '0;
                        tap   <= '0;
                        acc   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= (tap < 3'd3) ? (acc + prod_ext) : (acc - prod_ext);
                    if (tap == 3'd4) state <= WB;
                    else             tap   <= tap + 3'd1;
                end
                WB: begin
                    x2[stage] <= x1[stage];
                    x1[stage] <= x_cur;
                    y2[stage] <= y1[stage];
                    y1[stage] <= y_sat;
                    x_cur     <= y_sat;
                    acc       <= '0;
                    tap       <= '0;
                    if (last_stage) begin
                        sample_out_r       <= y_sat;
                        sample_out_valid_r <= 1'b1;
                        state              <= IDLE;
                    end else begin
                        stage <= stage + 1'b1;
                        state <= MAC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample_in_ready  = (state == IDLE);
    assign bus.sample_out       = sample_out_r;
    assign bus.sample_out_valid = sample_out_valid_r;
    assign bus.commit_pending   = commit_pending_r;
    assign bus.overrun_count    = overrun_count_r;
endmodule

// File: tb/tb_biquad_cascade_sequencer.sv
// Bench for biquad_cascade_sequencer. A timeline model computes each sample's cascade output
// with plain arithmetic at the accept edge and releases it 24 edges later.
module tb_biquad_cascade_sequencer;
    localparam int NS = 4;
    localparam int NC = 5*NS;
    localparam int LAT = 6*NS;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    biquad_cascade_sequencer_if #(.DATA_W(16), .COEF_W(16), .ADDR_W(5)) bus ();

    biquad_cascade_sequencer #(
        .NUM_STAGES(NS), .DATA_W(16), .COEF_W(16), .COEF_FRAC(14), .ACC_W(40), .ADDR_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model state
    int  m_act [NC];
    int  m_shd [NC];
    int  mx1 [NS], mx2 [NS], my1 [NS], my2 [NS];
    int  m_edge, m_acc_edge, m_res, m_out, m_ovr;
    bit  m_infl, m_valid, m_pend;

    function automatic int run_filter(input int x);
        int v = x;
        for (int s = 0; s < NS; s++) begin
            longint acc;
            longint q;
            int y;
            acc = longint'(m_act[s*5])   * v
                + longint'(m_act[s*5+1]) * mx1[s]
                + longint'(m_act[s*5+2]) * mx2[s]
                - longint'(m_act[s*5+3]) * my1[s]
                - longint'(m_act[s*5+4]) * my2[s];
            q = acc >>> 14;
            if (q > 32767) y = 32767;
            else if (q < -32768) y = -32768;
            else y = int'(q);
            mx2[s] = mx1[s];
            mx1[s] = v;
            my2[s] = my1[s];
            my1[s] = y;
            v = y;
        end
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        bit idle, final_wb, commit_now;
        if (!reset) begin
            for (int i = 0; i < NC; i++) begin
                m_act[i] = (i % 5 == 0) ? 16384 : 0;
                m_shd[i] = m_act[i];
            end
            for (int s = 0; s < NS; s++) begin
                mx1[s] = 0; mx2[s] = 0; my1[s] = 0; my2[s] = 0;
            end
            m_edge = 0; m_acc_edge = 0; m_res = 0; m_out = 0; m_ovr = 0;
            m_infl = 0; m_valid = 0; m_pend = 0;
        end else begin
            m_edge++;
            idle       = !m_infl;
            final_wb   = m_infl && (m_edge == m_acc_edge + LAT);
            commit_now = (m_pend || bus.coef_commit) && (idle || final_wb);
            if (commit_now) begin
                m_act  = m_shd;
                m_pend = 0;
            end else if (bus.coef_commit) m_pend = 1;
            if (bus.coef_wr_en && int'(bus.coef_wr_addr) < NC)
                m_shd[bus.coef_wr_addr] = int'(bus.coef_wr_data);
            m_valid = 0;
            if (final_wb) begin
                m_valid = 1;
                m_out   = m_res;
                m_infl  = 0;
            end
            if (bus.sample_in_valid) begin
                if (idle) begin
                    m_res      = run_filter(int'(bus.sample_in));
                    m_infl     = 1;
                    m_acc_edge = m_edge;
                end else if (m_ovr < 255) m_ovr++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_valid",   int'(bus.sample_out_valid), int'(m_valid));
            chk("cmp_out",     int'(bus.sample_out),       m_out);
            chk("cmp_ready",   int'(bus.sample_in_ready),  int'(!m_infl));
            chk("cmp_pending", int'(bus.commit_pending),   int'(m_pend));
            chk("cmp_overrun", int'(bus.overrun_count),    m_ovr);
        end
    end

    task automatic do_reset();
        @(posedge clk); #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_coef(input int addr, input int data);
        bus.coef_wr_en   = 1'b1;
        bus.coef_wr_addr = 5'(addr);
        bus.coef_wr_data = 16'(data);
        @(negedge clk);
        bus.coef_wr_en = 1'b0;
    endtask

    task automatic commit();
        bus.coef_commit = 1'b1;
        @(negedge clk);
        bus.coef_commit = 1'b0;
    endtask

    task automatic send(input int x);
        bus.sample_in       = 16'(x);
        bus.sample_in_valid = 1'b1;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic wait_out(input int exp, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_out_valid && n < 60);
        if (!bus.sample_out_valid) begin
            checks++;
            $display("FAIL %s_timeout: sample_out_valid not seen within %0d cycles", name, n);
        end else begin
            chk({name, "_val"}, int'(bus.sample_out), exp);
            chk({name, "_lat"}, cyc - acc_cyc, LAT);
        end
    endtask

    initial begin
        int pulses;
        bus.sample_in = '0; bus.sample_in_valid = 1'b0;
        bus.coef_wr_en = 1'b0; bus.coef_wr_addr = '0; bus.coef_wr_data = '0;
        bus.coef_commit = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk_en = 1;

        // 1: passthrough defaults
        chk("rst_out",     int'(bus.sample_out), 0);
        chk("rst_ready",   int'(bus.sample_in_ready), 1);
        chk("rst_pending", int'(bus.commit_pending), 0);
        chk("rst_overrun", int'(bus.overrun_count), 0);
        send(12345);
        chk("t1_busy", int'(bus.sample_in_ready), 0);
        wait_out(12345, "t1");
        @(negedge clk);
        chk("t1_pulse_once", int'(bus.sample_out_valid), 0);

        // 2: half gain with floor shift
        write_coef(0, 8192);
        commit();
        send(1000);   wait_out(500, "t2_pos");
        send(-1001);  wait_out(-501, "t2_neg");

        // 3: saturation
        write_coef(0, 32767);
        commit();
        send(30000);  wait_out(32767, "t3_pos");
        send(-30000); wait_out(-32768, "t3_neg");

        // 4: one-pole decay
        do_reset();
        write_coef(0, 16384);
        write_coef(3, -8192);
        commit();
        send(1000); wait_out(1000, "t4_0");
        send(0);    wait_out(500,  "t4_1");
        send(0);    wait_out(250,  "t4_2");
        send(0);    wait_out(125,  "t4_3");

        // 5: commit during a sample applies only at its final writeback
        do_reset();
        write_coef(0, 8192);
        send(2000);
        repeat (9) @(negedge clk);
        commit();
        chk("t5_pending_mid", int'(bus.commit_pending), 1);
        wait_out(2000, "t5_old");
        chk("t5_pending_clr", int'(bus.commit_pending), 0);
        send(2000); wait_out(1000, "t5_new");

        // random traffic: writes (incl. out-of-range), commits, strobes
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            bus.coef_wr_en      = ($urandom_range(0, 3) == 0);
            bus.coef_wr_addr    = 5'($urandom_range(0, 31));
            bus.coef_wr_data    = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                              : 16'($urandom_range(0, 16383) - 8192);
            bus.coef_commit     = ($urandom_range(0, 15) == 0);
            bus.sample_in_valid = ($urandom_range(0, 7) == 0);
            bus.sample_in       = 16'($urandom);
            @(negedge clk);
        end
        bus.coef_wr_en = 1'b0; bus.coef_commit = 1'b0; bus.sample_in_valid = 1'b0;
        repeat (30) @(negedge clk);

        // 6: overrun, saturation of the counter, reset mid-sample
        do_reset();
        send(100);
        repeat (4) @(negedge clk);
        bus.sample_in = 16'(777);
        bus.sample_in_valid = 1'b1;
        @(negedge clk);
        bus.sample_in_valid = 1'b0;
        wait_out(100, "t6_first");
        chk("t6_ovr1", int'(bus.overrun_count), 1);
        for (int i = 0; i < 400; i++) begin
            bus.sample_in = 16'($urandom);
            bus.sample_in_valid = 1'b1;
            @(negedge clk);
        end
        bus.sample_in_valid = 1'b0;
        @(negedge clk);
        chk("t6_ovr_sat", int'(bus.overrun_count), 255);
        repeat (30) @(negedge clk);
        send(1234);
        repeat (10) @(negedge clk);
        @(posedge clk); #2 reset = 1'b0;
        #1;
        chk("t6_rst_out",     int'(bus.sample_out), 0);
        chk("t6_rst_valid",   int'(bus.sample_out_valid), 0);
        chk("t6_rst_ready",   int'(bus.sample_in_ready), 1);
        chk("t6_rst_pending", int'(bus.commit_pending), 0);
        chk("t6_rst_overrun", int'(bus.overrun_count), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.sample_out_valid) pulses++;
        end
        chk("t6_no_partial", pulses, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
